// File: rtl/vga_fb_scan_arbiter.sv
// ----------------------------------------------------------------------------
// vga_fb_scan_arbiter
//
// Owns the single-port framebuffer RAM of the VGA path. Generates the video
// timing from the pixel clock and fetches one 3-bit framebuffer word every
// 4 active clocks. Each word covers a 4x4 block of screen pixels. Every RAM
// cycle not reserved for scanout is granted to a single host port.
//
// Pipeline: counters at t, RAM command at t+1, read data at t+2, pins at t+3.
//
// Ports:
//   i_clk          pixel clock
//   i_reset        synchronous active-high reset
//   i_host_valid   host request valid
//   i_host_write   1 = write, 0 = read
//   i_host_addr    linear framebuffer address (row*FB_W + col)
//   i_host_wdata   {R,G,B} write data
//   o_host_ready   request accepted this cycle (combinational, host slots only)
//   o_host_rvalid  read data valid, one-cycle pulse 2 clocks after accept
//   o_host_rdata   read data, held until the next pulse
//   o_mem_en       RAM enable (registered)
//   o_mem_we       RAM write enable (registered)
//   o_mem_addr     RAM address (registered)
//   o_mem_wdata    RAM write data (registered)
//   i_mem_rdata    RAM read data, valid the cycle after o_mem_en
//   o_r/o_g/o_b    pixel outputs (registered)
//   o_hsync        horizontal sync (registered)
//   o_vsync        vertical sync (registered)
//   o_vblank       high while the displayed line is past the active region
// ----------------------------------------------------------------------------
module vga_fb_scan_arbiter #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          SYNC_POL = 1'b1,
    parameter int unsigned FB_W     = 200,
    parameter int unsigned FB_H     = 150,
    parameter int unsigned AW       = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_host_valid,
    input  logic          i_host_write,
    input  logic [AW-1:0] i_host_addr,
    input  logic [2:0]    i_host_wdata,
    output logic          o_host_ready,
    output logic          o_host_rvalid,
    output logic [2:0]    o_host_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [2:0]    o_mem_wdata,
    input  logic [2:0]    i_mem_rdata,
    output logic          o_r,
    output logic          o_g,
    output logic          o_b,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_vblank
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   FB_SIZE   = (AW + 1)'(FB_W * FB_H);
    localparam logic [AW-1:0] FB_W_A    = AW'(FB_W);

    // ------------------------------------------------------------------
    // Timing counters and framebuffer row base
    // ------------------------------------------------------------------
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [AW-1:0] r_rowbase;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_act;
    logic w_v_act;
    logic w_active;
    logic w_scan_slot;
    logic w_hs_win;
    logic w_vs_win;
    logic w_vblank;

    assign w_h_wrap    = (r_hcnt == H_LAST);
    assign w_v_wrap    = (r_vcnt == V_LAST);
    assign w_h_act     = (r_hcnt < H_ACT_END);
    assign w_v_act     = (r_vcnt < V_ACT_END);
    assign w_active    = w_h_act && w_v_act;
    // First clock of every 4-pixel group in active video belongs to scanout.
    assign w_scan_slot = w_active && (r_hcnt[1:0] == 2'b00);
    assign w_hs_win    = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
    assign w_vs_win    = (r_vcnt >= VS_START) && (r_vcnt < VS_END);
    assign w_vblank    = !w_v_act;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_rowbase <= '0;
        end else if (w_h_wrap) begin
            r_hcnt <= '0;
            if (w_v_wrap) begin
                // Frame wrap clears the row base and wins over the row step.
                r_vcnt    <= '0;
                r_rowbase <= '0;
            end else begin
                r_vcnt <= r_vcnt + VW'(1);
                // Step to the next framebuffer row after every 4th active line.
                if ((r_vcnt[1:0] == 2'b11) && w_v_act) begin
                    r_rowbase <= r_rowbase + FB_W_A;
                end
            end
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Host handshake and RAM command stage (t+1)
    // ------------------------------------------------------------------
    logic          w_accept;
    logic          w_in_range;
    logic [AW-1:0] w_scan_addr;

    assign o_host_ready = !i_reset && !w_scan_slot;
    assign w_accept     = i_host_valid && o_host_ready;
    assign w_in_range   = ({1'b0, i_host_addr} < FB_SIZE);
    assign w_scan_addr  = r_rowbase + AW'(r_hcnt >> 2);

    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [2:0]    r_mem_wdata;
    logic          r_scan1;
    logic          r_rd1;
    logic          r_rd1_oor;
    logic          r_act1;
    logic          r_hs1;
    logic          r_vs1;
    logic          r_vb1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_scan1     <= 1'b0;
            r_rd1       <= 1'b0;
            r_rd1_oor   <= 1'b0;
            r_act1      <= 1'b0;
            r_hs1       <= 1'b0;
            r_vs1       <= 1'b0;
            r_vb1       <= 1'b0;
        end else begin
            r_scan1   <= w_scan_slot;
            // Out-of-range reads still return a pulse, with zero data.
            r_rd1     <= w_accept && !i_host_write;
            r_rd1_oor <= !w_in_range;
            r_act1    <= w_active;
            r_hs1     <= w_hs_win;
            r_vs1     <= w_vs_win;
            r_vb1     <= w_vblank;
            if (w_scan_slot) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_scan_addr;
            end else if (w_accept && w_in_range) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= i_host_write;
                r_mem_addr  <= i_host_addr;
                r_mem_wdata <= i_host_wdata;
            end else begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end
        end
    end

    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // Read-data stage (t+2)
    // ------------------------------------------------------------------
    logic       r_scan2;
    logic       r_rd2;
    logic       r_rd2_oor;
    logic       r_act2;
    logic       r_hs2;
    logic       r_vs2;
    logic       r_vb2;
    logic [2:0] r_rdata_hold;
    logic [2:0] r_pix;
    logic [2:0] w_rd_data;
    logic [2:0] w_pix;

    assign w_rd_data = r_rd2_oor ? 3'b000 : i_mem_rdata;
    // Fresh scan data is used directly so the pins land at t+3; r_pix keeps
    // it for the remaining three clocks of the group.
    assign w_pix     = r_scan2 ? i_mem_rdata : r_pix;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scan2      <= 1'b0;
            r_rd2        <= 1'b0;
            r_rd2_oor    <= 1'b0;
            r_act2       <= 1'b0;
            r_hs2        <= 1'b0;
            r_vs2        <= 1'b0;
            r_vb2        <= 1'b0;
            r_rdata_hold <= '0;
            r_pix        <= '0;
        end else begin
            r_scan2   <= r_scan1;
            r_rd2     <= r_rd1;
            r_rd2_oor <= r_rd1_oor;
            r_act2    <= r_act1;
            r_hs2     <= r_hs1;
            r_vs2     <= r_vs1;
            r_vb2     <= r_vb1;
            r_pix     <= w_pix;
            if (r_rd2) begin
                r_rdata_hold <= w_rd_data;
            end
        end
    end

    assign o_host_rvalid = r_rd2;
    assign o_host_rdata  = r_rd2 ? w_rd_data : r_rdata_hold;

    // ------------------------------------------------------------------
    // Pin stage (t+3)
    // ------------------------------------------------------------------
    logic [2:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_vblank;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rgb    <= '0;
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
            r_vblank <= 1'b0;
        end else begin
            r_rgb    <= r_act2 ? w_pix : 3'b000;
            r_hsync  <= r_hs2 ? SYNC_POL : ~SYNC_POL;
            r_vsync  <= r_vs2 ? SYNC_POL : ~SYNC_POL;
            r_vblank <= r_vb2;
        end
    end

    assign o_r      = r_rgb[2];
    assign o_g      = r_rgb[1];
    assign o_b      = r_rgb[0];
    assign o_hsync  = r_hsync;
    assign o_vsync  = r_vsync;
    assign o_vblank = r_vblank;

endmodule

// File: doc/vga_fb_scan_arbiter.md
# vga_fb_scan_arbiter

Owns the single-port framebuffer BRAM of the VGA path. Generates 800x600@60 timing from the 40 MHz pixel clock and fetches 4x4-scaled 3-bit pixels for scanout on reserved RAM slots. It grants every remaining RAM cycle to one host port (CPU or drawing engine) for reads and writes. It sits between the PLL/reset logic and the VGA pins, replacing a free-running pattern generator.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal porch and sync widths in clocks (line total 1056)
- V_ACTIVE, 600, visible lines
- V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porch and sync widths in lines (frame total 628)
- SYNC_POL, 1, active level of HSync and VSync
- FB_W / FB_H, 200 / 150, framebuffer columns and rows (H_ACTIVE/4, V_ACTIVE/4)
- AW, 15, framebuffer address width

Ports:
- Clock  in  1  pixel clock, 40 MHz
- Reset  in  1  synchronous, active-high
- HostValid  in  1  host request valid
- HostWrite  in  1  1 = write, 0 = read
- HostAddr  in  AW  linear pixel address (row*FB_W + col)
- HostWData  in  3  {R,G,B} write data
- HostReady  out  1  request accepted this cycle
- HostRValid  out  1  read data valid (one-cycle pulse)
- HostRData  out  3  read data
- MemEn  out  1  RAM enable, registered
- MemWe  out  1  RAM write enable, registered
- MemAddr  out  AW  RAM address, registered
- MemWData  out  3  RAM write data, registered
- MemRData  in  3  RAM read data, valid the cycle after MemEn (synchronous read)
- R, G, B  out  1 each  pixel outputs, registered
- HSync, VSync  out  1 each  sync outputs, registered
- VBlank  out  1  high while displayed line >= V_ACTIVE, registered

## Operation
- Counters:
  - hcnt runs 0..1055 and wraps to 0; on wrap, vcnt increments 0..627 and wraps to 0.
  - Active region: hcnt < 800 and vcnt < 600.
- Row base: a register rowbase (AW bits) is cleared at vcnt wrap. It adds FB_W when hcnt wraps and vcnt[1:0] == 3 with vcnt < 600. No multiplier.
- Scan slot: a cycle is reserved when the counters are in the active region and hcnt[1:0] == 0. The next cycle drives MemEn=1, MemWe=0, MemAddr = rowbase + (hcnt>>2).
- Host slot: any non-reserved cycle.
  - HostReady = 1 combinationally in host slots, outside reset.
  - A transfer occurs when HostValid && HostReady. The next cycle drives MemEn=1, MemWe=HostWrite, MemAddr=HostAddr, MemWData=HostWData.
  - When no transfer occurs, MemEn=0 in that following cycle.
- Out-of-range host address (>= FB_W*FB_H = 30000):
  - The request is still accepted.
  - MemEn stays 0 for that cycle.
  - A read returns HostRData = 0 with the normal HostRValid timing. A write is dropped.
- Read return: HostRValid pulses exactly 2 cycles after acceptance. HostRData is captured from MemRData and held until the next pulse.
- Pixel path: the scan fetch result is latched into a pixel register that holds for 4 clocks. R/G/B show the pixel register when the delayed position is active, otherwise 0.
- HSync = SYNC_POL while hcnt is in [840, 968); VSync = SYNC_POL while vcnt is in [601, 605); otherwise !SYNC_POL.
- Bandwidth: 3 of every 4 clocks go to the host during active video, and every clock goes to the host during blanking. The scan port never stalls.

## Timing
- Pipeline: R, G, B, HSync, VSync and VBlank at cycle t+3 reflect counter position (hcnt, vcnt) at cycle t.
  - t+1: Mem* driven.
  - t+2: MemRData captured.
  - t+3: pins.
- Host:
  - Accept at cycle a; Mem* driven at a+1; HostRValid at a+2.
  - Back-to-back accepts are allowed every host-slot cycle, giving up to 3 consecutive accepts per 4-clock group in active video.
- Reset values (cycle after Reset is sampled high):
  - hcnt = vcnt = rowbase = 0.
  - MemEn = MemWe = 0, MemAddr = 0, MemWData = 0.
  - R = G = B = 0; HSync = VSync = !SYNC_POL; VBlank = 0.
  - HostReady = 0, HostRValid = 0, HostRData = 0.
- Reset mid-operation:
  - All in-flight reads are discarded; no HostRValid is issued for them.
  - A write accepted in the cycle Reset is asserted is not committed.
  - After Reset deasserts, the first displayed pixel (0,0) reaches the pins 3 cycles after hcnt = 0.
- Simultaneous events:
  - hcnt and vcnt wrapping together resets rowbase to 0, overriding the +FB_W update.
  - HostValid arriving in a reserved slot waits; HostAddr/HostWData must be held until HostReady.

## Test plan
- Timing:
  - Stimulus: release Reset, run 2 frames.
  - Required: HSync period 1056, high for 128 clocks starting 843 clocks after hcnt = 0 (pipeline included); VSync period 663168 clocks, 4 lines high; VBlank high for 28 lines.
- Scanout addressing:
  - Stimulus: preload the RAM model with addr mod 8.
  - Required: pin pixel at screen (x=37, y=9) equals (2*200 + 9) mod 8 = 1; each framebuffer word spans 4x4 screen pixels; pins are 0 in blanking.
- Host write/read during active video:
  - Stimulus: HostValid held with writes to addr 1234 (value 5), then a read of 1234.
  - Required: HostReady is never high on hcnt[1:0] == 0 active cycles; RAM word 1234 = 5; HostRValid 2 cycles after accept with HostRData = 5.
- Streaming:
  - Stimulus: 1000 back-to-back writes held valid across a line boundary.
  - Required: in active video, exactly 3 accepts per 4 clocks; in blanking, 1 accept per clock; scan fetches are never skipped.
- Out-of-range access:
  - Stimulus: write to addr 30000, then read from addr 32767.
  - Required: MemEn stays 0 for both; HostRData = 0 with HostRValid on time.
- Reset mid-read:
  - Stimulus: accept a read, assert Reset on the next cycle.
  - Required: no HostRValid; all outputs at their reset values; clean frame start after release.
